// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer pixel write port between two
// requesters, with primitive locking and a burst cap. Macro PIX_ARB_CLIP_EN drops off-screen writes.
module pixel_write_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 64,
  parameter int FB_DEPTH  = 256000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              fb_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        grant,
  output logic              idle
`ifdef PIX_ARB_CLIP_EN
  ,
  output logic [15:0]       clip_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t              r_state, w_state_next;
  logic                r_last_owner, w_last_owner_next;
  logic [7:0]          r_burst, w_burst_next;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_owner1;
  logic                w_sel_valid, w_oth_valid, w_sel_last;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_acc, w_write;
  logic [8:0]          w_burst_inc;
  logic                w_burst_full;

  // Mux the owning requester's beat; in IDLE nothing is accepted so the mux value is irrelevant.
  assign w_owner1    = (r_state == S_OWN1);
  assign w_sel_valid = w_owner1 ? req1_valid : req0_valid;
  assign w_oth_valid = w_owner1 ? req0_valid : req1_valid;
  assign w_sel_last  = w_owner1 ? req1_last  : req0_last;
  assign w_sel_addr  = w_owner1 ? req1_addr  : req0_addr;
  assign w_sel_data  = w_owner1 ? req1_data  : req0_data;

  assign req0_ready  = (r_state == S_OWN0) && fb_ready;
  assign req1_ready  = (r_state == S_OWN1) && fb_ready;
  assign w_acc       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_burst_inc  = {1'b0, r_burst} + 9'd1;
  assign w_burst_full = (w_burst_inc >= 9'(MAX_BURST));

`ifdef PIX_ARB_CLIP_EN
  localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_DEPTH);
  logic w_in_range;
  assign w_in_range = ({1'b0, w_sel_addr} < FB_LIMIT);
  assign w_write    = w_acc && w_in_range;
`else
  assign w_write    = w_acc;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_burst_next      = r_burst;
    case (r_state)
      S_IDLE: begin
        w_burst_next = '0;
        if (req0_valid && req1_valid)
          w_state_next = r_last_owner ? S_OWN0 : S_OWN1;
        else if (req0_valid)
          w_state_next = S_OWN0;
        else if (req1_valid)
          w_state_next = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (w_acc)
          w_burst_next = w_burst_full ? 8'(MAX_BURST) : w_burst_inc[7:0];
        // Release on end of primitive, burst cap, or owner gone quiet while the other waits.
        if ((w_acc && (w_sel_last || w_burst_full)) || (!w_sel_valid && w_oth_valid)) begin
          w_state_next      = S_IDLE;
          w_last_owner_next = w_owner1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_burst      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_burst      <= w_burst_next;
      r_wr_en      <= w_write;
      if (w_write) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
    end
  end

`ifdef PIX_ARB_CLIP_EN
  logic [15:0] r_clip_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_clip_count <= '0;
    else if (w_acc && !w_in_range && (r_clip_count != 16'hFFFF))
      r_clip_count <= r_clip_count + 16'd1;
  end
  assign clip_count = r_clip_count;
`endif

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign grant   = {r_state == S_OWN1, r_state == S_OWN0};
  assign idle    = (r_state == S_IDLE) && !r_wr_en;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model of ownership and write results.
module tb_pixel_write_arbiter;
  localparam int AW = 18, DW = 4, MB = 4, DEPTH = 256000;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, fb_ready = 1'b0, wr_en, idle;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    grant;
`ifdef PIX_ARB_CLIP_EN
  logic [15:0]   clip_count;
`endif

  always #5 clk = ~clk;

  pixel_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .FB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .fb_ready(fb_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant(grant), .idle(idle)
`ifdef PIX_ARB_CLIP_EN
    , .clip_count(clip_count)
`endif
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic l; } beat_t;
  beat_t q0[$], q1[$];
  beat_t pb0, pb1;
  bit    pv0, pv1;

  // Model: owner -1 = nobody, otherwise requester index; writes are what the FB should see next.
  int            m_owner, m_last, m_cnt, m_clip;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic push(input int n, input int addr, input int data, input bit last);
    beat_t b;
    b = '{a: AW'(addr), d: DW'(data), l: last};
    if (n == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  function automatic logic [1:0] exp_grant();
    return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic sample();
    chk("wr_en",   32'(wr_en),   32'(m_wr));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("grant",   32'(grant),   32'(exp_grant()));
    chk("idle",    32'(idle),    32'((m_owner < 0) && !m_wr));
`ifdef PIX_ARB_CLIP_EN
    chk("clip_count", 32'(clip_count), 32'(m_clip));
`endif
  endtask

  task automatic drive_and_predict(input bit fb);
    beat_t b;
    bit    vn, vo;
    int    n;
    if (!pv0 && q0.size() > 0) begin pb0 = q0.pop_front(); pv0 = 1; end
    if (!pv1 && q1.size() > 0) begin pb1 = q1.pop_front(); pv1 = 1; end
    req0_valid = pv0; req0_addr = pb0.a; req0_data = pb0.d; req0_last = pb0.l;
    req1_valid = pv1; req1_addr = pb1.a; req1_data = pb1.d; req1_last = pb1.l;
    fb_ready = fb;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(m_owner == 0 && fb));
    chk("req1_ready", 32'(req1_ready), 32'(m_owner == 1 && fb));
    if (m_owner < 0) begin
      m_wr  = 1'b0;
      m_cnt = 0;
      if (pv0 && pv1) m_owner = (m_last == 1) ? 0 : 1;
      else if (pv0)   m_owner = 0;
      else if (pv1)   m_owner = 1;
    end else begin
      n  = m_owner;
      b  = (n == 1) ? pb1 : pb0;
      vn = (n == 1) ? pv1 : pv0;
      vo = (n == 1) ? pv0 : pv1;
      if (fb && vn) begin
        m_wr = 1'b1;
`ifdef PIX_ARB_CLIP_EN
        if (int'(b.a) >= DEPTH) begin
          m_wr = 1'b0;
          if (m_clip < 65535) m_clip++;
        end
`endif
        if (m_wr) begin m_addr = b.a; m_data = b.d; end
        m_cnt++;
        if (n == 1) pv1 = 0; else pv0 = 0;
        if (b.l || m_cnt >= MB) begin m_last = n; m_owner = -1; end
      end else begin
        m_wr = 1'b0;
        if (!vn && vo) begin m_last = n; m_owner = -1; end
      end
    end
  endtask

  task automatic step(input bit fb);
    @(posedge clk); #1;
    sample();
    drive_and_predict(fb);
  endtask

  // Asynchronous reset between edges, held across one edge, released just after it.
  task automatic do_reset(input bit fb);
    reset_n = 1'b0;
    #1;
    m_owner = -1; m_last = 1; m_cnt = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_clip = 0;
    chk("rst_wr_en",  32'(wr_en),      32'(m_wr));
    chk("rst_grant",  32'(grant),      32'(exp_grant()));
    chk("rst_idle",   32'(idle),       32'd1);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sample();
    drive_and_predict(fb);
  endtask

  initial begin
    bit reached;
    do_reset(1'b1);

    // Single requester, three-beat primitive.
    push(0, 10, 1, 0); push(0, 11, 2, 0); push(0, 12, 3, 1);
    repeat (8) step(1'b1);

    // Simultaneous contention straight out of reset.
    for (int i = 0; i < 3; i++) begin
      push(0, 100 + i, i + 1, i == 2);
      push(1, 200 + i, i + 5, i == 2);
    end
    do_reset(1'b1);
    repeat (14) step(1'b1);

    // Burst cap: long unterminated stream from req1 while req0 waits.
    for (int i = 0; i < 10; i++) push(1, 300 + i, i, 0);
    repeat (2) step(1'b1);
    push(0, 350, 9, 0); push(0, 351, 10, 1);
    repeat (30) step(1'b1);

    // Frame-buffer stall in the middle of a burst.
    for (int i = 0; i < 6; i++) push(0, 400 + i, i, i == 5);
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    repeat (10) step(1'b1);

`ifdef PIX_ARB_CLIP_EN
    push(0, 255999, 7, 0); push(0, 256000, 8, 1);
    repeat (6) step(1'b1);
`endif

    // Reset while req1 owns mid-burst, then contention must go to req0.
    for (int i = 0; i < 6; i++) push(1, 500 + i, i, i == 5);
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step(1'b1);
      reached = (m_owner == 1) && (m_cnt >= 2);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL own1_reach: observed not reached expected OWN1 mid-burst within 40 cycles");
    end
    push(0, 600, 3, 1);
    step(1'b1);
    do_reset(1'b1);
    repeat (20) step(1'b1);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        push(0, int'($urandom_range(0, 262143)), int'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        push(1, int'($urandom_range(0, 262143)), int'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
      step($urandom_range(0, 3) != 0);
    end
    repeat (40) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
